mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage core. Sits between the EX/MEM pipeline register and mem_wb_reg.
- Drives the data-memory bus using a req/gnt/rvalid handshake.
- Aligns store data and generates byte enables. Extracts and sign- or zero-extends load data.
- Requests a pipeline stall from flow control (fc) while a load is in flight. Produces op_c, waddr and we for mem_wb_reg.

Parameters:
- None. The datapath is fixed at 32 bits and the register address at 5 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- exmem_op_c_i  in  32  ALU result (memory address for loads/stores)
- exmem_op_b_i  in  32  store data (rs2)
- exmem_reg_waddr_i  in  5  destination register
- exmem_reg_we_i  in  1  register write enable
- exmem_mem_re_i  in  1  load
- exmem_mem_we_i  in  1  store
- exmem_mem_size_i  in  2  0=byte, 1=half, 2=word (3 treated as word)
- exmem_mem_uns_i  in  1  load zero-extend
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  bus write
- dmem_addr_o  out  32  word-aligned address ({op_c[31:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-aligned store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read data
- mem_op_c_o  out  32  result to mem_wb_reg
- mem_reg_waddr_o  out  5  to mem_wb_reg
- mem_reg_we_o  out  1  to mem_wb_reg
- mem_stall_req_o  out  1  to fc: block IF..EX/MEM and flush MEM/WB
- mem_misalign_o  out  1  misaligned access (1-cycle pulse per instruction)
- fc_bk_mem_i  in  1  fc hold: EX/MEM contents will repeat next cycle
- fc_flush_mem_i  in  1  fc kill of the current MEM instruction

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, killed=0, hold registers=0.
  - dmem_req_o=0, mem_stall_req_o=0, mem_misalign_o=0.
  - Remaining outputs are combinational from zero-reset upstream values, so they read 0.
- Misalignment:
  - half with addr[0]=1, or word with addr[1:0]!=0, on a load or store.
  - Response: mem_misalign_o=1, no bus request, mem_reg_we_o=0.
- Store:
  - be is 0001<<a (byte), 0011<<a (half, a∈{0,2}), or 1111 (word), where a=addr[1:0].
  - wdata replicates the byte/half across all lanes.
- Load:
  - Selects the byte/half at a from rdata, then sign- or zero-extends per exmem_mem_uns_i.
- FSM states: IDLE, WAIT_GNT, WAIT_RV, HOLD.
- IDLE, aligned load or store, no flush:
  - dmem_req_o=1.
  - gnt=1 and store: transaction complete (posted write). stall=0. Next state is HOLD if fc_bk_mem_i, else IDLE.
  - gnt=1 and load: stall=1, next state WAIT_RV.
  - gnt=0: stall=1, next state WAIT_GNT.
- WAIT_GNT:
  - req stays 1 with addr/wdata stable; stall=1.
  - On gnt, a store completes exactly as in IDLE; a load goes to WAIT_RV.
- WAIT_RV:
  - req=0, stall=1 until dmem_rvalid_i.
  - In the rvalid cycle: stall=0, mem_op_c_o=extended load data, we=exmem_reg_we_i&~killed.
  - Next state is HOLD if fc_bk_mem_i, else IDLE. rvalid arrives at the earliest one cycle after gnt.
- HOLD:
  - Never re-issues a completed access.
  - Outputs come from registered copies of the completed op_c, waddr and we; stall=0.
  - Returns to IDLE in the first cycle fc_bk_mem_i=0.
- Non-memory instruction (re=we=0):
  - mem_op_c_o=exmem_op_c_i, waddr/we pass through, zero latency, no stall.
- Flush:
  - fc_flush_mem_i in IDLE: no req issued, we=0.
  - fc_flush_mem_i in WAIT_GNT or WAIT_RV: killed=1. A request already asserted is held until gnt (the bus rule forbids dropping it). A load still drains its rvalid.
  - While killed: stall stays 1 and the result is discarded (we=0). killed clears on completion.
- Priority: rst_n > fc_flush_mem_i > fc_bk_mem_i > normal.
- mem_reg_we_o is 0 whenever mem_stall_req_o=1.

Test Plan:
- LW addr 0x100, gnt same cycle, rvalid next cycle with rdata 0x8000_00F0:
  - stall is 1 for exactly 1 cycle.
  - In the rvalid cycle, op_c=0x8000_00F0 and we=1.
- LB addr 0x103, rdata 0x80FF_FF7F, signed: op_c=0xFFFF_FF80. LBU at the same address: op_c=0x0000_0080.
- SH addr 0x202, op_b=0x1234_ABCD, gnt delayed 3 cycles:
  - req held 3 cycles with be=1100 and wdata=0xABCD_ABCD.
  - stall=1 during the wait; no stall in the gnt cycle.
- LW addr 0x101: mem_misalign_o=1, req=0, we=0, no stall.
- Load with rvalid coinciding with fc_bk_mem_i=1 for 2 cycles:
  - FSM enters HOLD and no second req is issued.
  - Held op_c stays stable until fc_bk_mem_i drops.
- Flush in WAIT_RV, then rvalid 2 cycles later: stall stays 1 until rvalid, then we=0; FSM returns to IDLE.
- Reset asserted in WAIT_RV: req and stall drop immediately and the FSM is in IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX/MEM and mem_wb_reg.
// Issues req/gnt/rvalid accesses, aligns stores, extends loads.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   exmem_*_i            instruction fields from the EX/MEM register
//   dmem_*_o / dmem_*_i  data-memory bus (req/gnt/rvalid handshake)
//   mem_op_c_o, mem_reg_waddr_o, mem_reg_we_o  result to mem_wb_reg
//   mem_stall_req_o      stall request to flow control
//   mem_misalign_o       misaligned access pulse
//   fc_bk_mem_i          EX/MEM contents repeat next cycle
//   fc_flush_mem_i       kill of the current MEM instruction
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] exmem_op_c_i,
   input  logic [31:0] exmem_op_b_i,
   input  logic [4:0]  exmem_reg_waddr_i,
   input  logic        exmem_reg_we_i,
   input  logic        exmem_mem_re_i,
   input  logic        exmem_mem_we_i,
   input  logic [1:0]  exmem_mem_size_i,
   input  logic        exmem_mem_uns_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic [31:0] mem_op_c_o,
   output logic [4:0]  mem_reg_waddr_o,
   output logic        mem_reg_we_o,
   output logic        mem_stall_req_o,
   output logic        mem_misalign_o,
   input  logic        fc_bk_mem_i,
   input  logic        fc_flush_mem_i
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RV,
      HOLD
   } state_t;

   state_t      state_q, state_d;
   logic        killed_q, killed_d;
   logic [31:0] hold_op_c_q;
   logic [4:0]  hold_waddr_q;
   logic        hold_we_q;
   logic        cap;

   logic [1:0]  a;
   logic        sz_b, sz_h;
   logic        is_ld, is_st, is_mem, mis;
   logic        kill;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_data;
   logic [3:0]  be;
   logic [31:0] wdata;

   logic        req, stall, misal, we;
   logic [31:0] op_c;
   logic [4:0]  waddr;

   // Decode, lane alignment and load extension
   always_comb begin
      a      = exmem_op_c_i[1:0];
      sz_b   = (exmem_mem_size_i == 2'd0);
      sz_h   = (exmem_mem_size_i == 2'd1);
      is_ld  = exmem_mem_re_i;
      is_st  = exmem_mem_we_i & ~exmem_mem_re_i;
      is_mem = is_ld | is_st;
      mis    = (sz_h & a[0]) |
               (~sz_b & ~sz_h & (a != 2'b00));
      ld_b   = dmem_rdata_i[{a, 3'b000} +: 8];
      ld_h   = dmem_rdata_i[{a[1], 4'b0000} +: 16];
      be      = 4'b1111;
      wdata   = exmem_op_b_i;
      ld_data = dmem_rdata_i;
      unique case (1'b1)
         sz_b: begin
            be      = 4'b0001 << a;
            wdata   = {4{exmem_op_b_i[7:0]}};
            ld_data = {{24{ld_b[7] & ~exmem_mem_uns_i}}, ld_b};
         end
         sz_h: begin
            be      = 4'b0011 << {a[1], 1'b0};
            wdata   = {2{exmem_op_b_i[15:0]}};
            ld_data = {{16{ld_h[15] & ~exmem_mem_uns_i}}, ld_h};
         end
         default: begin
            be      = 4'b1111;
            wdata   = exmem_op_b_i;
            ld_data = dmem_rdata_i;
         end
      endcase
   end

   // Next state and outputs
   always_comb begin
      state_d  = state_q;
      killed_d = killed_q;
      cap      = 1'b0;
      req      = 1'b0;
      stall    = 1'b0;
      misal    = 1'b0;
      kill     = killed_q | fc_flush_mem_i;
      op_c     = exmem_op_c_i;
      waddr    = exmem_reg_waddr_i;
      we       = exmem_reg_we_i;
      unique case (state_q)
         IDLE: begin
            if (fc_flush_mem_i) begin
               we = 1'b0;
            end else if (is_mem & mis) begin
               misal = 1'b1;
               we    = 1'b0;
               // park so a held instruction pulses only once
               if (fc_bk_mem_i) begin
                  state_d = HOLD;
                  cap     = 1'b1;
               end
            end else if (is_mem) begin
               req = 1'b1;
               if (dmem_gnt_i & is_st) begin
                  if (fc_bk_mem_i) begin
                     state_d = HOLD;
                     cap     = 1'b1;
                  end
               end else begin
                  stall   = 1'b1;
                  we      = 1'b0;
                  state_d = dmem_gnt_i ? WAIT_RV : WAIT_GNT;
               end
            end
         end
         WAIT_GNT: begin
            // request may not be dropped before gnt, even if killed
            req = 1'b1;
            if (dmem_gnt_i & is_st) begin
               we       = exmem_reg_we_i & ~kill;
               killed_d = 1'b0;
               cap      = fc_bk_mem_i;
               state_d  = fc_bk_mem_i ? HOLD : IDLE;
            end else begin
               stall    = 1'b1;
               we       = 1'b0;
               killed_d = kill;
               if (dmem_gnt_i) state_d = WAIT_RV;
            end
         end
         WAIT_RV: begin
            if (dmem_rvalid_i) begin
               op_c     = ld_data;
               we       = exmem_reg_we_i & ~kill;
               killed_d = 1'b0;
               cap      = fc_bk_mem_i;
               state_d  = fc_bk_mem_i ? HOLD : IDLE;
            end else begin
               stall    = 1'b1;
               we       = 1'b0;
               killed_d = kill;
            end
         end
         HOLD: begin
            op_c  = hold_op_c_q;
            waddr = hold_waddr_q;
            we    = hold_we_q & ~fc_flush_mem_i;
            if (!fc_bk_mem_i) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         killed_q     <= 1'b0;
         hold_op_c_q  <= '0;
         hold_waddr_q <= '0;
         hold_we_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         killed_q <= killed_d;
         if (cap) begin
            hold_op_c_q  <= op_c;
            hold_waddr_q <= waddr;
            hold_we_q    <= we;
         end
      end
   end

   // control outputs drop with reset regardless of upstream values
   assign dmem_req_o      = req & rst_n;
   assign dmem_we_o       = req & is_st & rst_n;
   assign dmem_addr_o     = {op_c[31:2], 2'b00};
   assign dmem_be_o       = be;
   assign dmem_wdata_o    = wdata;
   assign mem_op_c_o      = op_c;
   assign mem_reg_waddr_o = waddr;
   assign mem_reg_we_o    = we & ~stall;
   assign mem_stall_req_o = stall & rst_n;
   assign mem_misalign_o  = misal & rst_n;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage.
// Per-cycle model compare plus hand-computed literal checks.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] op_c, op_b;
   logic [4:0]  wa;
   logic        rwe, re, mwe, uns;
   logic [1:0]  sz;
   logic        req, bwe;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt, rvalid;
   logic [31:0] rdata;
   logic [31:0] o_op;
   logic [4:0]  o_wa;
   logic        o_we, stall, mis;
   logic        bk, flush;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .exmem_op_c_i      (op_c),
      .exmem_op_b_i      (op_b),
      .exmem_reg_waddr_i (wa),
      .exmem_reg_we_i    (rwe),
      .exmem_mem_re_i    (re),
      .exmem_mem_we_i    (mwe),
      .exmem_mem_size_i  (sz),
      .exmem_mem_uns_i   (uns),
      .dmem_req_o        (req),
      .dmem_we_o         (bwe),
      .dmem_addr_o       (addr),
      .dmem_be_o         (be),
      .dmem_wdata_o      (wdata),
      .dmem_gnt_i        (gnt),
      .dmem_rvalid_i     (rvalid),
      .dmem_rdata_i      (rdata),
      .mem_op_c_o        (o_op),
      .mem_reg_waddr_o   (o_wa),
      .mem_reg_we_o      (o_we),
      .mem_stall_req_o   (stall),
      .mem_misalign_o    (mis),
      .fc_bk_mem_i       (bk),
      .fc_flush_mem_i    (flush)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [3:0] f_be(input logic [1:0] s,
                                       input logic [1:0] a);
      logic [3:0] r = 4'b0000;
      for (int i = 0; i < 4; i++)
         if (i >= int'(a) && i < int'(a) + nbytes(s)) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] f_wd(input logic [1:0] s,
                                        input logic [31:0] b);
      logic [31:0] r = '0;
      int n = nbytes(s);
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = b[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] f_ld(input logic [31:0] d,
         input logic [1:0] s, input logic [1:0] a, input logic u);
      logic [31:0] v, m;
      int n = nbytes(s);
      if (n == 4) return d;
      v = d >> (8 * int'(a));
      m = (32'h1 << (8 * n)) - 32'h1;
      v = v & m;
      if (!u && v[8*n-1]) v = v | ~m;
      return v;
   endfunction

   // outstanding-access bookkeeping
   logic        m_wg, m_rv, m_dead, m_held, m_hwe;
   logic [31:0] m_hop;
   logic [4:0]  m_hwa;
   logic        n_wg, n_rv, n_dead, n_held, n_hwe;
   logic [31:0] n_hop;
   logic [4:0]  n_hwa;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wg <= 0; m_rv <= 0; m_dead <= 0; m_held <= 0;
         m_hop <= '0; m_hwa <= '0; m_hwe <= 0;
      end else begin
         m_wg <= n_wg; m_rv <= n_rv; m_dead <= n_dead;
         m_held <= n_held; m_hop <= n_hop;
         m_hwa <= n_hwa; m_hwe <= n_hwe;
      end
   end

   always @(negedge clk) begin
      logic st, ld, mem, ms, done;
      logic e_req, e_stall, e_mis, e_we;
      logic [31:0] e_op;
      logic [4:0]  e_wa;
      logic [1:0]  a;
      a   = op_c[1:0];
      ld  = re;
      st  = mwe && !re;
      mem = ld || st;
      ms  = mem && ((sz == 2'd1 && a[0]) ||
                    (sz >= 2'd2 && a != 2'd0));
      e_req = 0; e_stall = 0; e_mis = 0; done = 0;
      e_op = op_c; e_wa = wa; e_we = rwe;
      n_wg = 0; n_rv = 0; n_dead = 0; n_held = 0;
      n_hop = m_hop; n_hwa = m_hwa; n_hwe = m_hwe;
      if (m_held) begin
         e_op = m_hop; e_wa = m_hwa;
         e_we = m_hwe && !flush;
         n_held = bk;
      end else if (m_rv) begin
         if (rvalid) begin
            e_op = f_ld(rdata, sz, a, uns);
            e_we = rwe && !(m_dead || flush);
            done = 1;
         end else begin
            e_stall = 1; e_we = 0;
            n_rv = 1; n_dead = m_dead || flush;
         end
      end else if (m_wg || (mem && !ms && !flush)) begin
         e_req = 1;
         if (gnt && st) begin
            e_we = rwe && !(m_dead || flush);
            done = 1;
         end else begin
            e_stall = 1; e_we = 0;
            n_dead = m_wg && (m_dead || flush);
            if (gnt) n_rv = 1; else n_wg = 1;
         end
      end else if (mem && ms && !flush) begin
         e_mis = 1; e_we = 0; done = 1;
      end else if (flush) begin
         e_we = 0;
      end
      if (done && bk) begin
         n_held = 1; n_hop = e_op; n_hwa = e_wa; n_hwe = e_we;
      end
      if (!rst_n) begin
         chk("rst_req", 32'(req), 32'(0));
         chk("rst_stall", 32'(stall), 32'(0));
         chk("rst_mis", 32'(mis), 32'(0));
      end else begin
         chk("m_req", 32'(req), 32'(e_req));
         chk("m_stall", 32'(stall), 32'(e_stall));
         chk("m_mis", 32'(mis), 32'(e_mis));
         chk("m_we", 32'(o_we), 32'(e_we));
         chk("m_wa", 32'(o_wa), 32'(e_wa));
         chk("m_op_c", o_op, e_op);
         if (e_req) begin
            chk("m_addr", addr, {op_c[31:2], 2'b00});
            chk("m_bwe", 32'(bwe), 32'(st));
            chk("m_be", 32'(be), 32'(f_be(sz, a)));
            if (st) chk("m_wdata", wdata, f_wd(sz, op_b));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk); #1;
      gnt = 0; rvalid = 0; rdata = '0; bk = 0; flush = 0;
   endtask

   task automatic set_op(input logic r, input logic w,
         input logic [1:0] s, input logic u,
         input logic [31:0] ad, input logic [31:0] b,
         input logic [4:0] d, input logic e);
      re = r; mwe = w; sz = s; uns = u;
      op_c = ad; op_b = b; wa = d; rwe = e;
   endtask

   task automatic nop();
      set_op(0, 0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0);
   endtask

   // load with gnt in the issue cycle and rvalid one cycle later
   task automatic load1(input string nm, input logic [1:0] s,
         input logic u, input logic [31:0] ad,
         input logic [31:0] d, input logic [31:0] exp);
      nxt();
      set_op(1, 0, s, u, ad, 32'h0, 5'd7, 1);
      gnt = 1;
      @(negedge clk);
      chk({nm, "_stall0"}, 32'(stall), 32'(1));
      nxt();
      rvalid = 1; rdata = d;
      @(negedge clk);
      chk({nm, "_op"}, o_op, exp);
      chk({nm, "_we"}, 32'(o_we), 32'(1));
      nxt();
      nop();
   endtask

   initial begin
      rst_n = 0;
      nop();
      gnt = 0; rvalid = 0; rdata = '0; bk = 0; flush = 0;
      @(negedge clk);
      chk("reset_op_c", o_op, 32'h0);
      chk("reset_we", 32'(o_we), 32'(0));
      @(posedge clk); #1;
      rst_n = 1;

      // LW 0x100: one stall cycle, data in rvalid cycle
      nxt();
      set_op(1, 0, 2'd2, 0, 32'h100, 32'h0, 5'd3, 1);
      gnt = 1;
      @(negedge clk);
      chk("lw_req", 32'(req), 32'(1));
      chk("lw_stall", 32'(stall), 32'(1));
      nxt();
      rvalid = 1; rdata = 32'h8000_00F0;
      @(negedge clk);
      chk("lw_stall_rv", 32'(stall), 32'(0));
      chk("lw_op", o_op, 32'h8000_00F0);
      chk("lw_we", 32'(o_we), 32'(1));
      nxt();
      nop();

      load1("lb", 2'd0, 0, 32'h103, 32'h80FF_FF7F, 32'hFFFF_FF80);
      load1("lbu", 2'd0, 1, 32'h103, 32'h80FF_FF7F, 32'h0000_0080);
      load1("lh", 2'd1, 0, 32'h502, 32'h9ABC_1234, 32'hFFFF_9ABC);
      load1("lhu", 2'd1, 1, 32'h502, 32'h9ABC_1234, 32'h0000_9ABC);

      // SH 0x202 with gnt three cycles late
      nxt();
      set_op(0, 1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 5'd0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("sh_req", 32'(req), 32'(1));
         chk("sh_be", 32'(be), 32'(4'b1100));
         chk("sh_wdata", wdata, 32'hABCD_ABCD);
         chk("sh_stall", 32'(stall), 32'(1));
         nxt();
      end
      gnt = 1;
      @(negedge clk);
      chk("sh_gnt_req", 32'(req), 32'(1));
      chk("sh_gnt_stall", 32'(stall), 32'(0));
      nxt();
      nop();

      // SB with hold in the gnt cycle: no reissue next cycle
      nxt();
      set_op(0, 1, 2'd0, 0, 32'h11, 32'h0000_00A5, 5'd0, 0);
      gnt = 1; bk = 1;
      @(negedge clk);
      chk("sb_be", 32'(be), 32'(4'b0010));
      chk("sb_wdata", wdata, 32'hA5A5_A5A5);
      nxt();
      @(negedge clk);
      chk("sb_noreissue", 32'(req), 32'(0));
      nxt();
      nop();

      // misaligned LW
      nxt();
      set_op(1, 0, 2'd2, 0, 32'h101, 32'h0, 5'd4, 1);
      @(negedge clk);
      chk("mis_pulse", 32'(mis), 32'(1));
      chk("mis_req", 32'(req), 32'(0));
      chk("mis_we", 32'(o_we), 32'(0));
      chk("mis_stall", 32'(stall), 32'(0));
      nxt();
      nop();
      @(negedge clk);
      chk("mis_clear", 32'(mis), 32'(0));

      // load completing under a 2-cycle hold
      nxt();
      set_op(1, 0, 2'd2, 0, 32'h300, 32'h0, 5'd9, 1);
      gnt = 1;
      nxt();
      rvalid = 1; rdata = 32'hCAFE_BABE; bk = 1;
      @(negedge clk);
      chk("bk_op_rv", o_op, 32'hCAFE_BABE);
      nxt();
      bk = 1;
      @(negedge clk);
      chk("bk_req1", 32'(req), 32'(0));
      chk("bk_op1", o_op, 32'hCAFE_BABE);
      chk("bk_we1", 32'(o_we), 32'(1));
      nxt();
      @(negedge clk);
      chk("bk_req2", 32'(req), 32'(0));
      chk("bk_op2", o_op, 32'hCAFE_BABE);
      nxt();
      nop();

      // flush in WAIT_RV, rvalid two cycles later
      nxt();
      set_op(1, 0, 2'd2, 0, 32'h400, 32'h0, 5'd12, 1);
      gnt = 1;
      nxt();
      flush = 1;
      @(negedge clk);
      chk("fl_stall0", 32'(stall), 32'(1));
      nxt();
      @(negedge clk);
      chk("fl_stall1", 32'(stall), 32'(1));
      nxt();
      rvalid = 1; rdata = 32'h5555_5555;
      @(negedge clk);
      chk("fl_stall_rv", 32'(stall), 32'(0));
      chk("fl_we", 32'(o_we), 32'(0));
      nxt();
      nop();
      @(negedge clk);
      chk("fl_idle", 32'(stall), 32'(0));

      // reset while waiting for rvalid
      nxt();
      set_op(1, 0, 2'd2, 0, 32'h600, 32'h0, 5'd2, 1);
      gnt = 1;
      nxt();
      @(negedge clk);
      chk("rw_stall", 32'(stall), 32'(1));
      nxt();
      #1 rst_n = 0;
      @(negedge clk);
      chk("rw_req", 32'(req), 32'(0));
      chk("rw_stall0", 32'(stall), 32'(0));
      nxt();
      nop();
      rst_n = 1;
      @(negedge clk);
      chk("rw_idle", 32'(stall), 32'(0));
      nxt();
      nxt();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
